// File: rtl/md_pkg.sv
// Shared opcodes, default latencies and op classification for the multiply/divide unit.
// MD_MADD_EN enables the madd/maddu/msub/msubu accumulate opcodes.
package md_pkg;

    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MTHI  = 4'd5;
    localparam logic [3:0] MD_MTLO  = 4'd6;
    localparam logic [3:0] MD_MADD  = 4'd7;
    localparam logic [3:0] MD_MADDU = 4'd8;
    localparam logic [3:0] MD_MSUB  = 4'd9;
    localparam logic [3:0] MD_MSUBU = 4'd10;

    localparam int MD_MULT_LAT_DEF = 5;
    localparam int MD_DIV_LAT_DEF  = 10;

    function automatic logic is_multicycle(input logic [3:0] op);
        logic r;
        r = 1'b0;
        case (op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: r = 1'b1;
`ifdef MD_MADD_EN
            MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: r = 1'b1;
`endif
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational HI/LO result for a latched multiply/divide op, including all edge cases.
// The accumulate opcodes exist only when MD_MADD_EN is defined.
module md_calc
    import md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] hi_old,
    input  logic [WIDTH-1:0] lo_old,
    output logic [WIDTH-1:0] hi_next,
    output logic [WIDTH-1:0] lo_next
);

    localparam int W2 = 2 * WIDTH;
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    logic signed [W2-1:0]    prod_s;
    logic        [W2-1:0]    prod_u;
    logic signed [WIDTH-1:0] q_s;
    logic signed [WIDTH-1:0] r_s;
    logic        [WIDTH-1:0] q_u;
    logic        [WIDTH-1:0] r_u;
    logic                    div_zero;
    logic                    div_ovf;

    assign prod_s = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
    assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

    assign div_zero = (b == '0);
    assign div_ovf  = (a == MIN_VAL) && (b == '1);

    // Divider inputs are gated so the zero and MIN/-1 cases never reach the operators.
    always_comb begin
        q_s = '0;
        r_s = '0;
        q_u = '0;
        r_u = '0;
        if (!div_zero && !div_ovf) begin
            q_s = $signed(a) / $signed(b);
            r_s = $signed(a) % $signed(b);
        end
        if (!div_zero) begin
            q_u = a / b;
            r_u = a % b;
        end
    end

    always_comb begin
        hi_next = hi_old;
        lo_next = lo_old;
        case (op)
            MD_MULT:  {hi_next, lo_next} = prod_s;
            MD_MULTU: {hi_next, lo_next} = prod_u;
            MD_DIV: begin
                if (div_ovf) begin
                    lo_next = MIN_VAL;
                    hi_next = '0;
                end else if (!div_zero) begin
                    lo_next = q_s;
                    hi_next = r_s;
                end
            end
            MD_DIVU: begin
                if (!div_zero) begin
                    lo_next = q_u;
                    hi_next = r_u;
                end
            end
`ifdef MD_MADD_EN
            MD_MADD:  {hi_next, lo_next} = {hi_old, lo_old} + prod_s;
            MD_MADDU: {hi_next, lo_next} = {hi_old, lo_old} + prod_u;
            MD_MSUB:  {hi_next, lo_next} = {hi_old, lo_old} - prod_s;
            MD_MSUBU: {hi_next, lo_next} = {hi_old, lo_old} - prod_u;
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers and a busy down-counter for stalls.
// Define MD_MADD_EN to add the madd/maddu/msub/msubu accumulate opcodes.
module md_unit
    import md_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MULT_LAT = MD_MULT_LAT_DEF,
    parameter int DIV_LAT  = MD_DIV_LAT_DEF,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       md_op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             busy,
    output logic             stall_req,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] hi_res;
    logic [WIDTH-1:0] lo_res;
    logic             done;

    assign done      = busy && (cnt == CNT_ONE);
    assign stall_req = busy | (start & is_multicycle(md_op));

    // HI/LO cannot be written while busy, so the live registers equal their accept-time values.
    md_calc #(.WIDTH(WIDTH)) u_calc (
        .op      (op_q),
        .a       (a_q),
        .b       (b_q),
        .hi_old  (hi),
        .lo_old  (lo),
        .hi_next (hi_res),
        .lo_next (lo_res)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            busy <= 1'b0;
            op_q <= MD_NONE;
            a_q  <= '0;
            b_q  <= '0;
            hi   <= '0;
            lo   <= '0;
        end else if (busy) begin
            cnt <= cnt - CNT_ONE;
            if (done) begin
                busy <= 1'b0;
                op_q <= MD_NONE;
                hi   <= hi_res;
                lo   <= lo_res;
            end
        end else if (start) begin
            if (is_multicycle(md_op)) begin
                op_q <= md_op;
                a_q  <= rs_val;
                b_q  <= rt_val;
                busy <= 1'b1;
                cnt  <= is_div(md_op) ? DIV_CNT : MULT_CNT;
            end else if (md_op == MD_MTHI) begin
                hi <= rs_val;
            end else if (md_op == MD_MTLO) begin
                lo <= rs_val;
            end
        end
    end

`ifndef SYNTHESIS
    // A start while busy is dropped; the hazard unit is expected to hold it off.
    always @(posedge clk)
        if (!reset)
            assert (!(start && busy)) else $warning("md_unit: start while busy was ignored");
`endif

endmodule

// File: tb/tb_md_unit.sv
// Randomized self-checking bench for md_unit against a spec-level HI/LO reference model.
// Honours MD_MADD_EN the same way as the design.
module tb_md_unit;

    localparam int W  = 32;
    localparam int ML = 5;
    localparam int DL = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        busy;
    logic        stall_req;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    int          m_cnt;
    bit          m_upd;

    md_unit #(.WIDTH(W), .MULT_LAT(ML), .DIV_LAT(DL), .CNT_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .md_op     (md_op),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .busy      (busy),
        .stall_req (stall_req),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_is_multi(input logic [3:0] op);
        if (op >= 4'd1 && op <= 4'd4) return 1'b1;
`ifdef MD_MADD_EN
        if (op >= 4'd7 && op <= 4'd10) return 1'b1;
`endif
        return 1'b0;
    endfunction

    task automatic m_reset();
        m_hi = '0; m_lo = '0; m_cnt = 0; m_upd = 1'b0;
    endtask

    // Result is fixed at accept time from the HI/LO value current then.
    task automatic m_accept(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub, qm, rm;
        logic [63:0] prod, acc;
        m_upd = 1'b1;
        acc   = {m_hi, m_lo};
        sa    = longint'($signed(a));
        sb    = longint'($signed(b));
        prod  = '0;
        if (op == 4'd1 || op == 4'd7 || op == 4'd9) prod = sa * sb;
        if (op == 4'd2 || op == 4'd8 || op == 4'd10) prod = {32'h0, a} * {32'h0, b};
        case (op)
            4'd1, 4'd2: {p_hi, p_lo} = prod;
            4'd7, 4'd8: {p_hi, p_lo} = acc + prod;
            4'd9, 4'd10: {p_hi, p_lo} = acc - prod;
            4'd3: begin
                if (b == 32'h0) m_upd = 1'b0;
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
                    p_lo = 32'h80000000; p_hi = 32'h0;
                end else begin
                    ua = (sa < 0) ? -sa : sa;
                    ub = (sb < 0) ? -sb : sb;
                    qm = ua / ub;
                    rm = ua % ub;
                    if ((sa < 0) != (sb < 0)) qm = -qm;
                    if (sa < 0) rm = -rm;
                    p_lo = qm[31:0];
                    p_hi = rm[31:0];
                end
            end
            4'd4: begin
                if (b == 32'h0) m_upd = 1'b0;
                else begin p_lo = a / b; p_hi = a % b; end
            end
            default: m_upd = 1'b0;
        endcase
        m_cnt = (op == 4'd3 || op == 4'd4) ? DL : ML;
    endtask

    task automatic m_step();
        if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0 && m_upd) begin m_hi = p_hi; m_lo = p_lo; end
        end else if (start) begin
            if (m_is_multi(md_op)) m_accept(md_op, rs_val, rt_val);
            else if (md_op == 4'd5) m_hi = rs_val;
            else if (md_op == 4'd6) m_lo = rs_val;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset) m_step();
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", busy, m_cnt > 0);
            chk("hi", hi, m_hi);
            chk("lo", lo, m_lo);
            chk("stall_req", stall_req, (m_cnt > 0) || (start && m_is_multi(md_op)));
        end
    end

    // Issues one op and returns how many cycles busy stayed high afterwards.
    task automatic run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, output int n);
        start = 1'b1; md_op = op; rs_val = a; rt_val = b;
        tick();
        start = 1'b0; md_op = 4'd0;
        n = 0;
        while (busy && n < 40) begin n++; tick(); end
    endtask

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom();
        endcase
    endfunction

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; md_op = 4'd0; rs_val = '0; rt_val = '0;
        m_reset();
        tick(); tick();
        chk("reset_busy", busy, 1'b0);
        chk("reset_hi", hi, 32'h0);
        chk("reset_lo", lo, 32'h0);
        reset = 1'b0;
        chk_en = 1'b1;
        tick();

        run(4'd1, 32'hFFFFFFFE, 32'd3, n);
        chk("mult_cycles", n, ML);
        chk("mult_hi", hi, 32'hFFFFFFFF);
        chk("mult_lo", lo, 32'hFFFFFFFA);

        run(4'd2, 32'hFFFFFFFE, 32'd3, n);
        chk("multu_hi", hi, 32'h00000002);
        chk("multu_lo", lo, 32'hFFFFFFFA);

        run(4'd3, 32'hFFFFFFF9, 32'd2, n);
        chk("div_cycles", n, DL);
        chk("div_lo", lo, 32'hFFFFFFFD);
        chk("div_hi", hi, 32'hFFFFFFFF);

        run(4'd5, 32'h11, 32'h0, n);
        run(4'd6, 32'h22, 32'h0, n);
        run(4'd4, 32'd7, 32'd0, n);
        chk("divz_cycles", n, DL);
        chk("divz_hi", hi, 32'h11);
        chk("divz_lo", lo, 32'h22);

        run(4'd3, 32'h80000000, 32'hFFFFFFFF, n);
        chk("ovf_lo", lo, 32'h80000000);
        chk("ovf_hi", hi, 32'h0);

        run(4'd5, 32'hABCD, 32'h0, n);
        chk("mthi_busy_cycles", n, 0);
        chk("mthi_hi", hi, 32'hABCD);
        chk("mthi_lo", lo, 32'h80000000);

        // contention: divu issued on the second busy cycle of a mult
        start = 1'b1; md_op = 4'd1; rs_val = 32'hFFFFFFFE; rt_val = 32'd3;
        #1 chk("cont_stall_accept", stall_req, 1'b1);
        tick();
        start = 1'b0; md_op = 4'd0;
        n = 0;
        while (busy && n < 40) begin
            n++;
            if (n == 2) begin start = 1'b1; md_op = 4'd4; rs_val = 32'd100; rt_val = 32'd7; end
            tick();
            start = 1'b0; md_op = 4'd0;
        end
        chk("cont_cycles", n, ML);
        chk("cont_hi", hi, 32'hFFFFFFFF);
        chk("cont_lo", lo, 32'hFFFFFFFA);

        // asynchronous reset on busy cycle 4 of a div
        start = 1'b1; md_op = 4'd3; rs_val = 32'd100; rt_val = 32'd7;
        tick();
        start = 1'b0; md_op = 4'd0;
        tick(); tick(); tick();
        #2 reset = 1'b1;
        m_reset();
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_hi", hi, 32'h0);
        chk("arst_lo", lo, 32'h0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        chk("arst_after_hi", hi, 32'h0);
        chk("arst_after_lo", lo, 32'h0);

        run(4'd6, 32'hFFFFFFFF, 32'h0, n);
        run(4'd8, 32'd1, 32'd1, n);
`ifdef MD_MADD_EN
        chk("maddu_cycles", n, ML);
        chk("maddu_hi", hi, 32'h1);
        chk("maddu_lo", lo, 32'h0);
`else
        chk("maddu_off_cycles", n, 0);
        chk("maddu_off_hi", hi, 32'h0);
        chk("maddu_off_lo", lo, 32'hFFFFFFFF);
`endif

        for (int i = 0; i < 3000; i++) begin
            md_op  = 4'($urandom_range(0, 15));
            rs_val = rnd_opnd();
            rt_val = rnd_opnd();
            start  = (m_cnt == 0) && ($urandom_range(0, 2) == 0);
            tick();
        end
        start = 1'b0;
        for (int i = 0; i < 12; i++) tick();

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
